memory_port_arbiter: RTL and testbench

- Shares the single off-chip memory port between the instruction cache (I-side) and the data cache (D-side) of the cached multi-cycle CPU.
- Line fills are bursts of LINE_WORDS words. Data writes are single-word, write-through.
- The caches hold their miss request high until the matching done pulse. Each cache turns "request pending and no done" into its stall_mem to the pipeline registers.
- Memory is fixed-latency: address and command are held MEM_LATENCY cycles per word, and there is no ready signal.

---
 rtl/memory_port_arbiter_pkg.sv | 27 ++
 rtl/memory_port_arbiter_access_counter.sv | 46 ++++
 rtl/memory_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_port_arbiter_pkg.sv
// Shared encodings and defaults for the I/D memory port arbiter.
// Also carries the line-base helper used to build fill addresses.
package memory_port_arbiter_pkg;

    localparam int DEFAULT_MEM_LATENCY = 4;
    localparam int DEFAULT_LINE_WORDS  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_I_FILL  = 2'd1,
        ARB_D_FILL  = 2'd2,
        ARB_D_WRITE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Clears the word-offset bits so the fill always starts at word 0 of the line.
    function automatic logic [15:0] line_base(input logic [15:0] addr, input int idx_w);
        logic [15:0] mask;
        mask = 16'((32'd1 << idx_w) - 32'd1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/memory_port_arbiter_access_counter.sv
// Per-word latency counter and per-line word counter for one memory transaction.
// start advances both counters; clear returns them to zero between transactions.
module mem_access_counter
    import memory_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int LINE_WORDS  = DEFAULT_LINE_WORDS,
    parameter int IDX_W       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             clear,
    output logic             word_last_cycle,
    output logic             line_last_word,
    output logic [IDX_W-1:0] word_cnt
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(LINE_WORDS - 1);

    logic [LAT_W-1:0] lat_cnt;

    assign word_last_cycle = (lat_cnt == LAT_LAST);
    assign line_last_word  = (word_cnt == WORD_LAST);

    // word_cnt wraps back to zero naturally as the last word of a line completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt  <= '0;
            word_cnt <= '0;
        end else if (clear) begin
            lat_cnt  <= '0;
            word_cnt <= '0;
        end else if (start) begin
            if (word_last_cycle) begin
                lat_cnt  <= '0;
                word_cnt <= word_cnt + IDX_W'(1);
            end else begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between I-cache fills
// and D-cache fills / write-through stores. A request is held until its done pulse.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int LINE_WORDS  = DEFAULT_LINE_WORDS,
    parameter int IDX_W       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_req,
    input  logic [15:0]      i_addr,
    output logic [15:0]      i_rdata,
    output logic             i_word_valid,
    output logic [IDX_W-1:0] i_word_idx,
    output logic             i_done,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [15:0]      d_addr,
    input  logic [15:0]      d_wdata,
    output logic [15:0]      d_rdata,
    output logic             d_word_valid,
    output logic [IDX_W-1:0] d_word_idx,
    output logic             d_done,
    output logic             mem_read,
    output logic             mem_write,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    output logic [1:0]       dbg_state
);

    arb_state_t state, next_state;
    grant_t     last_grant, grant;
    logic       grant_valid;
    logic [15:0] addr_q, wdata_q;
    logic [15:0] fill_addr;

    logic             cnt_start, cnt_clear;
    logic             word_last_cycle, line_last_word;
    logic [IDX_W-1:0] word_cnt;

    mem_access_counter #(
        .MEM_LATENCY (MEM_LATENCY),
        .LINE_WORDS  (LINE_WORDS),
        .IDX_W       (IDX_W)
    ) u_counter (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (cnt_start),
        .clear           (cnt_clear),
        .word_last_cycle (word_last_cycle),
        .line_last_word  (line_last_word),
        .word_cnt        (word_cnt)
    );

    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign dbg_state = state;
    assign fill_addr = line_base(addr_q, IDX_W) | 16'(word_cnt);

    // On a tie, the side that did not win last time gets the port.
    always_comb begin
        grant_valid = i_req | d_req;
        grant       = GRANT_I;
        if (i_req && d_req) begin
            grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            grant = GRANT_D;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state <= next_state;
            if (state == ARB_IDLE && grant_valid) begin
                last_grant <= grant;
                addr_q     <= (grant == GRANT_D) ? d_addr : i_addr;
                wdata_q    <= d_wdata;
            end
        end
    end

    always_comb begin
        next_state   = state;
        cnt_start    = 1'b0;
        cnt_clear    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        i_word_valid = 1'b0;
        i_word_idx   = '0;
        i_done       = 1'b0;
        d_word_valid = 1'b0;
        d_word_idx   = '0;
        d_done       = 1'b0;
        case (state)
            ARB_IDLE: begin
                cnt_clear = 1'b1;
                if (grant_valid) begin
                    if (grant == GRANT_I) begin
                        next_state = ARB_I_FILL;
                    end else begin
                        next_state = d_we ? ARB_D_WRITE : ARB_D_FILL;
                    end
                end
            end
            ARB_I_FILL: begin
                cnt_start = 1'b1;
                mem_read  = 1'b1;
                mem_addr  = fill_addr;
                if (word_last_cycle) begin
                    i_word_valid = 1'b1;
                    i_word_idx   = word_cnt;
                    if (line_last_word) begin
                        i_done     = 1'b1;
                        next_state = ARB_IDLE;
                    end
                end
            end
            ARB_D_FILL: begin
                cnt_start = 1'b1;
                mem_read  = 1'b1;
                mem_addr  = fill_addr;
                if (word_last_cycle) begin
                    d_word_valid = 1'b1;
                    d_word_idx   = word_cnt;
                    if (line_last_word) begin
                        d_done     = 1'b1;
                        next_state = ARB_IDLE;
                    end
                end
            end
            ARB_D_WRITE: begin
                // Stores use the unaligned address and a single word access.
                cnt_start = 1'b1;
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (word_last_cycle) begin
                    d_done     = 1'b1;
                    next_state = ARB_IDLE;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: fills, stores, arbitration and reset.
// Word deliveries are checked in order against an expected queue.
module tb_memory_port_arbiter;
    import memory_port_arbiter_pkg::*;

    localparam int W = 19;

    logic        clk, reset_n;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_word_valid, i_done, d_word_valid, d_done;
    logic [1:0]  i_word_idx, d_word_idx, dbg_state;
    logic        mem_read, mem_write;

    int n_checks = 0;
    int n_errors = 0;
    int i_done_cnt = 0;
    int d_done_cnt = 0;
    logic [W-1:0] exp_q[$];

    memory_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_word_valid(i_word_valid), .i_word_idx(i_word_idx), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_word_valid(d_word_valid), .d_word_idx(d_word_idx),
        .d_done(d_done), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // Clock and a simple memory model whose read data is a function of the address.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign mem_rdata = mem_addr ^ 16'hA5A5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input logic side, input logic [15:0] base);
        for (int i = 0; i < 4; i++) exp_q.push_back({side, 2'(i), base + 16'(i)});
    endtask

    task automatic do_reset();
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        reset_n = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic wait_done(input logic side, input int max, output int cycles);
        logic seen;
        seen = 0;
        cycles = 0;
        while (!seen && cycles < max) begin
            @(negedge clk);
            cycles++;
            seen = side ? d_done : i_done;
        end
        check(side ? "d_done_seen" : "i_done_seen", 32'(seen), 1);
    endtask

    // Scoreboard: invariants every cycle, word order against exp_q, done counts.
    always @(negedge clk) begin
        logic have;
        check("rw_exclusive", 32'(mem_read & mem_write), 0);
        check("valid_exclusive", 32'(i_word_valid & d_word_valid), 0);
        if (i_word_valid || d_word_valid) begin
            have = (exp_q.size() != 0);
            check("word_expected", 32'(have), 1);
            if (have) begin
                if (i_word_valid) check("i_word", 32'({1'b0, i_word_idx, mem_addr}), 32'(exp_q.pop_front()));
                else              check("d_word", 32'({1'b1, d_word_idx, mem_addr}), 32'(exp_q.pop_front()));
            end
            check("rdata", 32'(i_word_valid ? i_rdata : d_rdata), 32'(mem_addr ^ 16'hA5A5));
        end
        if (i_done) i_done_cnt++;
        if (d_done) d_done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int done_before;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        reset_n = 0;
        #1;
        check("rst_read", 32'(mem_read), 0);
        check("rst_write", 32'(mem_write), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_done", 32'({i_done, d_done}), 0);
        check("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;

        // I fill alone from 0x0123.
        i_req = 1; i_addr = 16'h0123;
        push_line(1'b0, 16'h0120);
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check("s1_read", 32'(mem_read), 1);
            check("s1_write", 32'(mem_write), 0);
            check("s1_addr", 32'(mem_addr), 32'(16'h0120 + 16'((c - 1) / 4)));
            check("s1_valid", 32'(i_word_valid), 32'(c % 4 == 0));
            check("s1_done", 32'(i_done), 32'(c == 16));
            check("s1_d_quiet", 32'({d_word_valid, d_done}), 0);
            if (c == 16) i_req = 0;
        end
        @(negedge clk);
        check("s1_idle_read", 32'(mem_read), 0);
        check("s1_idle_state", 32'(dbg_state), 32'(ARB_IDLE));

        // Tie right after reset goes to D.
        do_reset();
        i_req = 1; i_addr = 16'h1238;
        d_req = 1; d_we = 0; d_addr = 16'h4005;
        push_line(1'b1, 16'h4004);
        push_line(1'b0, 16'h1238);
        @(posedge clk);
        wait_done(1'b1, 40, cyc);
        check("s2_d_cycles", 32'(cyc), 16);
        d_req = 0;
        @(negedge clk);
        check("s2_gap_state", 32'(dbg_state), 32'(ARB_IDLE));
        check("s2_gap_read", 32'(mem_read), 0);
        wait_done(1'b0, 40, cyc);
        check("s2_i_cycles", 32'(cyc), 16);
        i_req = 0;
        @(negedge clk);

        // D write; inputs changed after grant must be ignored.
        d_req = 1; d_we = 1; d_addr = 16'h00F3; d_wdata = 16'hBEEF;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("s3_write", 32'(mem_write), 1);
            check("s3_read", 32'(mem_read), 0);
            check("s3_addr", 32'(mem_addr), 32'h00F3);
            check("s3_wdata", 32'(mem_wdata), 32'hBEEF);
            check("s3_done", 32'(d_done), 32'(c == 4));
            check("s3_dvalid", 32'(d_word_valid), 0);
            if (c == 1) begin d_addr = 16'hFFFF; d_wdata = 16'h0000; end
            if (c == 4) begin d_req = 0; d_we = 0; end
        end
        @(negedge clk);
        check("s3_idle_write", 32'(mem_write), 0);

        // Round robin: D held, I arrives mid-fill; order D, I, D.
        d_req = 1; d_we = 0; d_addr = 16'h2000; i_addr = 16'h3000;
        push_line(1'b1, 16'h2000);
        push_line(1'b0, 16'h3000);
        push_line(1'b1, 16'h2000);
        @(posedge clk);
        repeat (5) @(negedge clk);
        i_req = 1;
        wait_done(1'b1, 40, cyc);
        check("s4_d1_cycles", 32'(cyc), 11);
        wait_done(1'b0, 40, cyc);
        check("s4_i_cycles", 32'(cyc), 17);
        i_req = 0;
        wait_done(1'b1, 40, cyc);
        check("s4_d2_cycles", 32'(cyc), 17);
        d_req = 0;
        @(negedge clk);

        // Reset during the second word of an I fill.
        i_req = 1; i_addr = 16'h0500;
        exp_q.push_back({1'b0, 2'd0, 16'h0500});
        @(posedge clk);
        repeat (6) @(negedge clk);
        check("s5_pre_read", 32'(mem_read), 1);
        reset_n = 0;
        #1;
        check("s5_async_read", 32'(mem_read), 0);
        check("s5_async_addr", 32'(mem_addr), 0);
        check("s5_async_state", 32'(dbg_state), 32'(ARB_IDLE));
        check("s5_async_done", 32'(i_done), 0);
        i_req = 0;
        done_before = i_done_cnt;
        repeat (2) @(negedge clk);
        reset_n = 1;
        i_req = 1; i_addr = 16'h0600;
        d_req = 1; d_we = 0; d_addr = 16'h6002;
        push_line(1'b1, 16'h6000);
        push_line(1'b0, 16'h0600);
        @(posedge clk);
        wait_done(1'b1, 40, cyc);
        check("s5_d_cycles", 32'(cyc), 16);
        d_req = 0;
        wait_done(1'b0, 40, cyc);
        check("s5_i_cycles", 32'(cyc), 17);
        i_req = 0;
        @(negedge clk);
        #1;
        check("s5_no_abort_done", 32'(i_done_cnt), 32'(done_before + 1));

        // Request withdrawn at cycle 6 still completes.
        i_req = 1; i_addr = 16'h7771;
        push_line(1'b0, 16'h7770);
        @(posedge clk);
        repeat (6) @(negedge clk);
        i_req = 0;
        wait_done(1'b0, 40, cyc);
        check("s6_i_cycles", 32'(cyc), 10);
        @(negedge clk);
        @(negedge clk);
        #1;

        check("final_queue_empty", 32'(exp_q.size()), 0);
        check("final_i_done_cnt", 32'(i_done_cnt), 5);
        check("final_d_done_cnt", 32'(d_done_cnt), 5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
